nv_sync_tog2evt: RTL

NV_SYNC_TOG2EVT -- requirements
Module: nv_sync_tog2evt

---
 rtl/nv_sync_tog2evt.sv | 136 +++++++++++++
 1 files changed

// File: rtl/nv_sync_tog2evt.sv
// -----------------------------------------------------------------------------
// nv_sync_tog2evt
//
// Converts a synchronized toggle level into counted event batches. Every change
// of sync_tog (either polarity) is one event. Batches are offered to a consumer
// with a valid/ready handshake. While a batch waits for the consumer, further
// events collect in an accumulator. On a handshake, the accumulated events plus
// any event in that same cycle become the next batch, with no idle cycle
// between batches. Counts saturate at 2^CW-1, and a sticky flag records any
// events lost to saturation.
//
// Parameters
//   CW       width of the event-count field (2..8)
//   RST_VAL  reset value of the toggle history; matches the synchronizer's
//            set-on-reset output so that reset itself is not seen as an event
//
// Ports
//   clk       input        single clock for all state
//   rst       input        asynchronous, active-high reset
//   sync_tog  input        toggle level, already synchronized into clk
//   evt_rdy   input        consumer ready; ignored while no batch is presented
//   ovf_clr   input        clears evt_ovf (a same-cycle set takes priority)
//   evt_vld   output       an event batch is presented
//   evt_cnt   output [CW]  event count of the presented batch; 0 when idle
//   evt_ovf   output       sticky: events were lost to saturation
// -----------------------------------------------------------------------------
module nv_sync_tog2evt #(
    parameter int CW      = 4,
    parameter bit RST_VAL = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sync_tog,
    input  logic          evt_rdy,
    input  logic          ovf_clr,
    output logic          evt_vld,
    output logic [CW-1:0] evt_cnt,
    output logic          evt_ovf
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          tog_q;
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          ovf_q, ovf_d;

    logic          tog_edge;
    logic          acc_full;
    logic [CW-1:0] acc_inc;
    logic          ovf_set;

    // One event per level change, in either direction.
    assign tog_edge = sync_tog ^ tog_q;

    // acc + edge, held at CNT_MAX so that it never wraps. This value is the
    // next accumulator while the batch waits, and the next batch on a handshake.
    assign acc_full = (acc_q == CNT_MAX);
    assign acc_inc  = acc_full ? CNT_MAX : acc_q + {{(CW-1){1'b0}}, tog_edge};

    // An event is lost only when its destination is already saturated. In IDLE
    // the destination is the fresh batch count (1), so no event is lost there.
    assign ovf_set = (state_q == ST_BUSY) && tog_edge && acc_full;

    // NOTE: every combinational output gets a default before the case, so a
    // path that does not assign a signal still leaves it driven and no latch
    // is inferred.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        out_cnt_d = out_cnt_q;
        ovf_d     = ovf_q;

        // The set term comes after the clear term, so set wins in the same cycle.
        if (ovf_clr) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (tog_edge) begin
                    out_cnt_d = CW'(1);
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!evt_rdy) begin
                    // The presented batch stays frozen. New events go to acc.
                    acc_d = acc_inc;
                end else if (acc_inc != '0) begin
                    // Next batch starts at once, with this cycle's edge included.
                    out_cnt_d = acc_inc;
                    acc_d     = '0;
                end else begin
                    out_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                out_cnt_d = '0;
                acc_d     = '0;
            end
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments. Every flop then
    // samples pre-edge values, whatever the order of the statements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tog_q     <= RST_VAL;
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            out_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            tog_q     <= sync_tog;
            state_q   <= state_d;
            acc_q     <= acc_d;
            out_cnt_q <= out_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // All outputs come straight from flops. The state is a single-bit
    // encoding, so this comparison reduces to a buffer.
    assign evt_vld = (state_q == ST_BUSY);
    assign evt_cnt = out_cnt_q;
    assign evt_ovf = ovf_q;

endmodule
